// File: rtl/gmii_tx_framer.sv
// Store-and-forward GMII transmit framer: buffers whole packets in a circular buffer, then
// emits optional preamble/SFD, the packet bytes and a fixed inter-frame gap.
module gmii_tx_framer #(
  parameter int unsigned FIFO_DEPTH  = 2048,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned IFG_BYTES   = 12,
  parameter bit          PREAMBLE_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        iv_pkt_data,
  input  logic              i_pkt_data_wr,
  input  logic              i_pkt_last,
  output logic              o_fifo_overflow_pulse,
  output logic [ADDR_W:0]   ov_pkt_cnt,
  output logic [7:0]        ov_gmii_txd,
  output logic              o_gmii_tx_en,
  output logic              o_gmii_tx_er
);

  localparam logic [ADDR_W:0] Depth   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PtrOne  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [7:0]      IfgLast = 8'(IFG_BYTES - 1);

  typedef enum logic {StWr, StDrop} wr_state_e;
  typedef enum logic [1:0] {StIdle, StPre, StData, StIfg} rd_state_e;

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] pkt_cnt_q, pkt_cnt_d;
  logic [2:0]      pre_cnt_q, pre_cnt_d;
  logic [7:0]      ifg_cnt_q, ifg_cnt_d;
  logic [7:0]      txd_q, txd_d;
  logic            tx_en_q, tx_en_d;
  logic            ovf_q, ovf_d;
  logic            full, mem_we, commit, frame_end;

  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [8:0]      rd_data_q;

  assign full = (wr_ptr_q - rd_ptr_q) == Depth;

  // Write side: accept bytes, commit on last, roll back the open packet on overflow.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    ovf_d        = 1'b0;
    unique case (wr_state_q)
      StWr: begin
        if (i_pkt_data_wr) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            if (i_pkt_last) begin
              commit_ptr_d = wr_ptr_q + PtrOne;
              commit       = 1'b1;
            end
          end else begin
            ovf_d    = 1'b1;
            wr_ptr_d = commit_ptr_q;
            if (!i_pkt_last) wr_state_d = StDrop;
          end
        end
      end
      StDrop: begin
        if (i_pkt_data_wr && i_pkt_last) wr_state_d = StWr;
      end
      default: wr_state_d = StWr;
    endcase
  end

  // Read side: outputs are computed here and registered, so they trail the state by a cycle.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    txd_d      = 8'h00;
    tx_en_d    = 1'b0;
    frame_end  = 1'b0;
    unique case (rd_state_q)
      StIdle: begin
        pre_cnt_d = 3'd0;
        if (pkt_cnt_q != '0) rd_state_d = PREAMBLE_EN ? StPre : StData;
      end
      StPre: begin
        tx_en_d   = 1'b1;
        txd_d     = (pre_cnt_q == 3'd7) ? 8'hd5 : 8'h55;
        pre_cnt_d = pre_cnt_q + 3'd1;
        if (pre_cnt_q == 3'd7) rd_state_d = StData;
      end
      StData: begin
        tx_en_d  = 1'b1;
        txd_d    = rd_data_q[7:0];
        rd_ptr_d = rd_ptr_q + PtrOne;
        if (rd_data_q[8]) begin
          frame_end  = 1'b1;
          ifg_cnt_d  = 8'd0;
          rd_state_d = StIfg;
        end
      end
      StIfg: begin
        ifg_cnt_d = ifg_cnt_q + 8'd1;
        if (ifg_cnt_q == IfgLast) rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({commit, frame_end})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PtrOne;
      2'b01:   pkt_cnt_d = pkt_cnt_q - PtrOne;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state_q   <= StWr;
      rd_state_q   <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      pre_cnt_q    <= '0;
      ifg_cnt_q    <= '0;
      txd_q        <= '0;
      tx_en_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      ovf_q        <= ovf_d;
    end
  end

  // Read address is the next pointer, so rd_data_q always holds the entry at rd_ptr_q.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {i_pkt_last, iv_pkt_data};
    rd_data_q <= mem_q[rd_ptr_d[ADDR_W-1:0]];
  end

  assign o_fifo_overflow_pulse = ovf_q;
  assign ov_pkt_cnt            = pkt_cnt_q;
  assign ov_gmii_txd           = txd_q;
  assign o_gmii_tx_en          = tx_en_q;
  assign o_gmii_tx_er          = 1'b0;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: a 2048-byte instance for framing/timing and a
// 64-byte instance for overflow behaviour.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  [2];
  logic       wr    [2];
  logic       last  [2];
  logic       pulse [2];
  logic [7:0] txd   [2];
  logic       tx_en [2];
  logic       tx_er [2];
  logic [11:0] cnt_b;
  logic [6:0]  cnt_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] cap [2][2048];
  int cap_n [2], nf [2], low_run [2], pulses [2], pulse_cyc [2];
  int fstart [2][32], flen [2][32], fgap [2][32];
  logic prev_en [2];
  int max_cnt_b = 0;

  always #4 clk = ~clk;

  gmii_tx_framer #(.FIFO_DEPTH(2048), .ADDR_W(11), .IFG_BYTES(12), .PREAMBLE_EN(1'b1)) u_dut_big (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(data[0]), .i_pkt_data_wr(wr[0]),
    .i_pkt_last(last[0]), .o_fifo_overflow_pulse(pulse[0]), .ov_pkt_cnt(cnt_b),
    .ov_gmii_txd(txd[0]), .o_gmii_tx_en(tx_en[0]), .o_gmii_tx_er(tx_er[0])
  );

  gmii_tx_framer #(.FIFO_DEPTH(64), .ADDR_W(6), .IFG_BYTES(12), .PREAMBLE_EN(1'b1)) u_dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(data[1]), .i_pkt_data_wr(wr[1]),
    .i_pkt_last(last[1]), .o_fifo_overflow_pulse(pulse[1]), .ov_pkt_cnt(cnt_s),
    .ov_gmii_txd(txd[1]), .o_gmii_tx_en(tx_en[1]), .o_gmii_tx_er(tx_er[1])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame capture on the falling edge, away from the active edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      cap_n[i] = 0; nf[i] = 0; low_run[i] = 0; pulses[i] = 0; pulse_cyc[i] = 0;
      prev_en[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pulse[i]) begin
          pulses[i]++;
          pulse_cyc[i] = cyc;
        end
        if (tx_en[i]) begin
          if (!prev_en[i]) begin
            if (nf[i] < 32) begin
              fstart[i][nf[i]] = cap_n[i];
              fgap[i][nf[i]]   = low_run[i];
              flen[i][nf[i]]   = 0;
            end
            nf[i]++;
          end
          if (nf[i] <= 32) flen[i][nf[i]-1]++;
          if (cap_n[i] < 2048) cap[i][cap_n[i]] = txd[i];
          cap_n[i]++;
          low_run[i] = 0;
        end else begin
          low_run[i]++;
        end
        prev_en[i] = tx_en[i];
      end
      if (int'(cnt_b) > max_cnt_b) max_cnt_b = int'(cnt_b);
    end
  end

  task automatic send_pkt(input int i, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) begin
      wr[i]   = 1'b1;
      last[i] = (k == len - 1);
      data[i] = 8'(base + k);
      @(posedge clk); #1;
    end
    wr[i] = 1'b0; last[i] = 1'b0; data[i] = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (((i == 0 ? int'(cnt_b) : int'(cnt_s)) != 0 || tx_en[i]) && n < budget) begin
      step(1);
      n++;
    end
    check_eq("idle_reached", int'(n < budget), 1);
    step(16);
  endtask

  // Expected frame: 7x55, D5, then len bytes base, base+1, ...
  task automatic check_frame(input string tag, input int i, input int fi, input int len,
                             input logic [7:0] base, input int gap);
    int n;
    logic [7:0] e;
    check_eq({tag, "_present"}, int'(fi < nf[i]), 1);
    if (fi < nf[i] && fi < 32) begin
      check_eq({tag, "_len"}, flen[i][fi], len + 8);
      if (gap >= 0) check_eq({tag, "_gap"}, fgap[i][fi], gap);
      n = (flen[i][fi] < len + 8) ? flen[i][fi] : len + 8;
      for (int k = 0; k < n; k++) begin
        e = (k < 7) ? 8'h55 : (k == 7) ? 8'hd5 : 8'(base + k - 8);
        check_eq($sformatf("%s_b%0d", tag, k), int'(cap[i][fstart[i][fi] + k]), int'(e));
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0, f1, p1, t0;
    for (int i = 0; i < 2; i++) begin
      data[i] = 8'h00; wr[i] = 1'b0; last[i] = 1'b0;
    end
    rst_n = 1'b0;
    step(3);
    check_eq("rst_tx_en", int'(tx_en[0]), 0);
    check_eq("rst_txd", int'(txd[0]), 0);
    check_eq("rst_tx_er", int'(tx_er[0]), 0);
    check_eq("rst_cnt", int'(cnt_b), 0);
    check_eq("rst_pulse", int'(pulse[0]), 0);
    check_eq("rst_cnt_s", int'(cnt_s), 0);
    rst_n = 1'b1;
    step(1);

    // T1: single 64-byte packet, latency and framing
    f0 = nf[0];
    send_pkt(0, 64, 8'h10);
    check_eq("t1_cnt", int'(cnt_b), 1);
    step(1);
    check_eq("t1_lat_n1", int'(tx_en[0]), 0);
    step(1);
    check_eq("t1_lat_n2", int'(tx_en[0]), 1);
    check_eq("t1_first_txd", int'(txd[0]), 'h55);
    check_eq("t1_tx_er", int'(tx_er[0]), 0);
    wait_idle(0, 200);
    check_frame("t1", 0, f0, 64, 8'h10, -1);
    check_eq("t1_ifg_low", int'(low_run[0] >= 12), 1);

    // T2: 100B frame keeps the framer busy while three 60B packets queue up
    f0 = nf[0];
    send_pkt(0, 100, 8'h20);
    send_pkt(0, 60, 8'h40);
    send_pkt(0, 60, 8'h80);
    send_pkt(0, 60, 8'hc0);
    check_eq("t2_cnt_three", int'(cnt_b), 3);
    wait_idle(0, 600);
    check_eq("t2_cnt_peak", max_cnt_b, 3);
    check_eq("t2_cnt_end", int'(cnt_b), 0);
    check_eq("t2_frames", nf[0] - f0, 4);
    check_frame("t2_p0", 0, f0, 100, 8'h20, -1);
    check_frame("t2_p1", 0, f0 + 1, 60, 8'h40, 13);
    check_frame("t2_p2", 0, f0 + 2, 60, 8'h80, 13);
    check_frame("t2_p3", 0, f0 + 3, 60, 8'hc0, 13);

    // T5: B's last byte lands on the edge where A's frame ends
    f0 = nf[0];
    send_pkt(0, 20, 8'h05);
    send_pkt(0, 29, 8'h60);
    check_eq("t5_cnt_hold", int'(cnt_b), 1);
    check_eq("t5_a_last_en", int'(tx_en[0]), 1);
    check_eq("t5_a_last_txd", int'(txd[0]), 'h18);
    wait_idle(0, 300);
    check_frame("t5_a", 0, f0, 20, 8'h05, -1);
    check_frame("t5_b", 0, f0 + 1, 29, 8'h60, 13);

    // T3: 100B packet into an empty 64B buffer drops at byte 65
    f1 = nf[1]; p1 = pulses[1]; t0 = cyc;
    send_pkt(1, 100, 8'h00);
    step(20);
    check_eq("t3_pulses", pulses[1] - p1, 1);
    check_eq("t3_pulse_byte", pulse_cyc[1] - t0, 65);
    check_eq("t3_cnt", int'(cnt_s), 0);
    check_eq("t3_no_tx", nf[1] - f1, 0);
    send_pkt(1, 40, 8'h30);
    check_eq("t3_cnt_next", int'(cnt_s), 1);
    wait_idle(1, 200);
    check_frame("t3_next", 1, f1, 40, 8'h30, -1);

    // T4: last byte hits a full buffer; the following packet is taken immediately
    f1 = nf[1]; p1 = pulses[1]; t0 = cyc;
    send_pkt(1, 65, 8'h90);
    send_pkt(1, 10, 8'ha0);
    check_eq("t4_cnt", int'(cnt_s), 1);
    wait_idle(1, 200);
    check_eq("t4_pulses", pulses[1] - p1, 1);
    check_eq("t4_pulse_byte", pulse_cyc[1] - t0, 65);
    check_eq("t4_frames", nf[1] - f1, 1);
    check_frame("t4_next", 1, f1, 10, 8'ha0, -1);

    // T6: asynchronous reset in the middle of a data phase
    send_pkt(0, 40, 8'h33);
    step(15);
    check_eq("t6_mid_en", int'(tx_en[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en", int'(tx_en[0]), 0);
    check_eq("t6_rst_txd", int'(txd[0]), 0);
    check_eq("t6_rst_cnt", int'(cnt_b), 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check_eq("t6_post_en", int'(tx_en[0]), 0);
    check_eq("t6_post_cnt", int'(cnt_b), 0);
    f0 = nf[0];
    send_pkt(0, 10, 8'he0);
    wait_idle(0, 200);
    check_eq("t6_frames", nf[0] - f0, 1);
    check_frame("t6_next", 0, f0, 10, 8'he0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
